// File: rtl/inst_fetch.sv
// Instruction fetch stage for the single-issue RV32 core.
// Owns the fetch PC and keeps at most one instruction-memory request in flight.
// Each fetched word is held toward decode until it is consumed or redirected.
//
// Handshake rules: a transfer happens on a rising edge where valid && ready
// are both high. Once a valid is raised, the payload stays stable until that
// transfer happens; a redirect from execute is the only exception. The memory
// response channel has no ready: the response is a single-cycle pulse, one
// per accepted request.
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    // instruction memory request channel
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    // instruction memory response channel
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    // decode channel
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] pc,
    // redirect from execute
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    // FSM state, for debug and checkers
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              flush_q, flush_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inst_valid_q, inst_valid_d;

    // Redirect targets are always word aligned; the low two bits are dropped.
    logic [ADDR_W-1:0] redirect_target;
    assign redirect_target = redirect_pc & ~ADDR_W'(3);

    // State and datapath registers; reset aborts any transaction immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_BOOT;
            fetch_pc_q   <= RESET_PC;
            flush_q      <= 1'b0;
            inst_q       <= 32'h0;
            pc_q         <= RESET_PC;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            flush_q      <= flush_d;
            inst_q       <= inst_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Next-state and next-datapath logic; a redirect always beats the +4 step.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        flush_d      = flush_q;
        inst_d       = inst_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;

        case (state_q)
            S_BOOT: begin
                // Redirects are ignored here; fetch always starts at RESET_PC.
                state_d = S_REQ;
            end

            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                    if (redirect_valid) begin
                        // The request just accepted is stale; drop its response.
                        fetch_pc_d = redirect_target;
                        flush_d    = 1'b1;
                    end
                end else if (redirect_valid) begin
                    // Nothing is in flight, so just retarget the pending request.
                    fetch_pc_d = redirect_target;
                end
            end

            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                    if (redirect_valid) begin
                        // Response and redirect collide: the response is stale.
                        fetch_pc_d = redirect_target;
                        flush_d    = 1'b0;
                    end else if (flush_q) begin
                        flush_d = 1'b0;
                    end else begin
                        // With no flush pending, fetch_pc is still the request address.
                        inst_d       = imem_resp_data;
                        pc_d         = fetch_pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    fetch_pc_d = redirect_target;
                    flush_d    = 1'b1;
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    // The held word is on the wrong path and is never re-presented.
                    fetch_pc_d   = redirect_target;
                    inst_valid_d = 1'b0;
                    state_d      = S_REQ;
                end else if (inst_ready) begin
                    fetch_pc_d   = fetch_pc_q + ADDR_W'(4);
                    inst_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end

            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // Request channel outputs are Moore outputs of state and fetch_pc.
    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = fetch_pc_q;

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign dbg_state  = state_q;

    // A pending request keeps its address until it is accepted or redirected.
    a_req_stable: assert property (
        @(posedge clk) disable iff (rst)
        (imem_req_valid && !imem_req_ready && !redirect_valid)
            |=> (imem_req_valid && $stable(imem_req_addr))
    );

    // A presented instruction is stable until decode takes it or a redirect kills it.
    a_inst_stable: assert property (
        @(posedge clk) disable iff (rst)
        (inst_valid && !inst_ready && !redirect_valid)
            |=> (inst_valid && $stable(inst) && $stable(pc))
    );

    // Requests are always word aligned.
    a_req_aligned: assert property (
        @(posedge clk) disable iff (rst)
        imem_req_valid |-> (imem_req_addr[1:0] == 2'b00)
    );

    // Only one request is ever in flight: no request while an instruction is held.
    a_no_overlap: assert property (
        @(posedge clk) disable iff (rst)
        inst_valid |-> !imem_req_valid
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a table of straight-line fetches, a run
// of randomised fetches, and hand-written sequences for redirects, PC wrap and
// asynchronous reset. Expected {pc, inst} pairs are queued when a memory
// response is driven and popped when the word shows up toward decode.
module tb_inst_fetch;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    inst_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .pc              (pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dbg_state       (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        leak_seen = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          req_stall;
        int          resp_lat;
        int          dec_stall;
    } vec_t;

    // A flushed response must never be presented to decode.
    always @(negedge clk) begin
        if (!rst && inst_valid && inst === 32'hDEAD_BEEF) leak_seen <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    // Drive one fetch up to the point where the word is held toward decode.
    task automatic fetch_to_hold(input logic [31:0] addr, input logic [31:0] data,
                                 input int req_stall, input int resp_lat);
        int          n;
        logic [63:0] e;
        n = 0;
        while (!imem_req_valid && n < 20) begin
            step();
            n++;
        end
        check("req_valid", 32'(imem_req_valid), 32'd1);
        check("req_addr", imem_req_addr, addr);
        imem_req_ready = 1'b0;
        for (int i = 0; i < req_stall; i++) begin
            step();
            check("stall_req_valid", 32'(imem_req_valid), 32'd1);
            check("stall_req_addr", imem_req_addr, addr);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("wait_req_valid", 32'(imem_req_valid), 32'd0);
        check("wait_inst_valid", 32'(inst_valid), 32'd0);
        for (int i = 1; i < resp_lat; i++) begin
            step();
            check("wait_idle_req_valid", 32'(imem_req_valid), 32'd0);
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        exp_q.push_back({addr, data});
        step();
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        check("hold_inst_valid", 32'(inst_valid), 32'd1);
        e = exp_q.pop_front();
        check("hold_inst", inst, e[31:0]);
        check("hold_pc", pc, e[63:32]);
    endtask

    // Stall decode, then consume; the next request must be addr + 4.
    task automatic consume(input logic [31:0] addr, input logic [31:0] data, input int dec_stall);
        logic [31:0] next_addr;
        next_addr  = addr + 32'd4;
        inst_ready = 1'b0;
        for (int i = 0; i < dec_stall; i++) begin
            // A stray response outside WAIT must be ignored.
            imem_resp_valid = (i == 1);
            imem_resp_data  = 32'hBAD0_BAD0;
            step();
            imem_resp_valid = 1'b0;
            check("dec_stall_valid", 32'(inst_valid), 32'd1);
            check("dec_stall_inst", inst, data);
            check("dec_stall_pc", pc, addr);
            check("dec_stall_no_req", 32'(imem_req_valid), 32'd0);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("consumed_inst_valid", 32'(inst_valid), 32'd0);
        check("next_req_valid", 32'(imem_req_valid), 32'd1);
        check("next_req_addr", imem_req_addr, next_addr);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vec_t        vecs[4];
        vec_t        v;
        logic [31:0] a;

        vecs[0] = '{32'h8000_0000, 32'h0050_0093, 0, 1, 5};
        vecs[1] = '{32'h8000_0004, 32'h0010_0113, 4, 1, 0};
        vecs[2] = '{32'h8000_0008, 32'h0020_8193, 0, 3, 1};
        vecs[3] = '{32'h8000_000C, 32'h0000_0013, 2, 2, 2};

        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", pc, RESET_PC);

        // Release reset with a redirect and a stale response in BOOT: both ignored.
        rst             = 1'b0;
        redirect_valid  = 1'b1;
        redirect_pc     = 32'h1234_0000;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hFFFF_0000;
        step();
        redirect_valid  = 1'b0;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, RESET_PC);
        step();
        imem_resp_valid = 1'b0;
        check("stray_resp_req_valid", 32'(imem_req_valid), 32'd1);
        check("stray_resp_inst_valid", 32'(inst_valid), 32'd0);

        // Table of straight-line fetches.
        for (int k = 0; k < 4; k++) begin
            fetch_to_hold(vecs[k].addr, vecs[k].data, vecs[k].req_stall, vecs[k].resp_lat);
            consume(vecs[k].addr, vecs[k].data, vecs[k].dec_stall);
        end

        // Randomised fetches continuing the sequential stream.
        for (int k = 0; k < 6; k++) begin
            v.addr      = 32'h8000_0010 + 32'(4 * k);
            v.data      = $urandom & 32'h7FFF_FFFF;
            v.req_stall = $urandom_range(0, 3);
            v.resp_lat  = $urandom_range(1, 3);
            v.dec_stall = $urandom_range(0, 3);
            fetch_to_hold(v.addr, v.data, v.req_stall, v.resp_lat);
            consume(v.addr, v.data, v.dec_stall);
        end

        // Redirect in REQ without handshake; low bits of the target are dropped.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_4001;
        step();
        redirect_valid = 1'b0;
        check("req_redirect_valid", 32'(imem_req_valid), 32'd1);
        check("req_redirect_addr", imem_req_addr, 32'h8000_4000);
        fetch_to_hold(32'h8000_4000, 32'h0040_0513, 0, 1);
        consume(32'h8000_4000, 32'h0040_0513, 0);

        // Redirect in REQ on the handshake cycle: the stale response is dropped.
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_3000;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        check("hs_redirect_wait", 32'(imem_req_valid), 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        step();
        imem_resp_valid = 1'b0;
        check("hs_redirect_inst_valid", 32'(inst_valid), 32'd0);
        check("hs_redirect_req_addr", imem_req_addr, 32'h8000_3000);
        fetch_to_hold(32'h8000_3000, 32'h0030_0593, 0, 1);
        consume(32'h8000_3000, 32'h0030_0593, 0);

        // Redirect in WAIT, response two cycles later.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        step();
        redirect_valid = 1'b0;
        check("wait_redirect_no_req", 32'(imem_req_valid), 32'd0);
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        step();
        imem_resp_valid = 1'b0;
        check("wait_redirect_inst_valid", 32'(inst_valid), 32'd0);
        check("wait_redirect_req_valid", 32'(imem_req_valid), 32'd1);
        check("wait_redirect_req_addr", imem_req_addr, 32'h8000_0100);
        fetch_to_hold(32'h8000_0100, 32'h0060_0613, 1, 2);
        consume(32'h8000_0100, 32'h0060_0613, 0);

        // Redirect in WAIT on the same cycle as the response.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        redirect_valid  = 1'b1;
        redirect_pc     = 32'h8000_5000;
        step();
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        check("resp_redirect_inst_valid", 32'(inst_valid), 32'd0);
        check("resp_redirect_req_addr", imem_req_addr, 32'h8000_5000);
        fetch_to_hold(32'h8000_5000, 32'h0070_0693, 0, 1);
        consume(32'h8000_5000, 32'h0070_0693, 0);

        // Redirect in HOLD together with inst_ready: redirect wins over +4.
        fetch_to_hold(32'h8000_5004, 32'h0080_0713, 0, 1);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_2000;
        step();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        check("hold_redirect_inst_valid", 32'(inst_valid), 32'd0);
        check("hold_redirect_req_valid", 32'(imem_req_valid), 32'd1);
        check("hold_redirect_req_addr", imem_req_addr, 32'h8000_2000);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        fetch_to_hold(32'hFFFF_FFFC, 32'h0090_0793, 0, 1);
        consume(32'hFFFF_FFFC, 32'h0090_0793, 1);

        // Reset asserted in WAIT between clock edges: outputs go back at once.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("pre_rst_wait", 32'(imem_req_valid), 32'd0);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("async_rst_req_addr", imem_req_addr, RESET_PC);
        check("async_rst_inst_valid", 32'(inst_valid), 32'd0);
        check("async_rst_inst", inst, 32'h0);
        check("async_rst_pc", pc, RESET_PC);

        // Recover from reset and fetch once more.
        step();
        rst = 1'b0;
        step();
        a = RESET_PC;
        fetch_to_hold(a, 32'h00A0_0813, 0, 1);
        consume(a, 32'h00A0_0813, 0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("flushed_word_leak", 32'(leak_seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Bound on total run time in case the DUT wedges a handshake.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
